// File: rtl/max10nios_request_handshake.sv
// Avalon-MM slave that runs a four-phase req/ack handshake with an external agent.
// Provides status and timeout flags, a completion counter and a level interrupt.
module max10nios_request_handshake #(
  parameter int TO_W            = 16,
  parameter int TIMEOUT_DEFAULT = 1000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ack_in,
  output logic        req_out,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_ack_meta;
  logic                r_ack_s;
  logic                r_req;
  logic                r_irq;
  logic                r_irq_en;
  logic                r_done;
  logic                r_to_err;
  logic [TO_W-1:0]     r_timeout;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_to_on;
  logic [CNT_W-1:0]    r_count;

  logic w_wr;
  logic w_start;
  logic w_abort;
  logic w_clr_done;
  logic w_clr_to;
  logic w_wr_to;
  logic w_wr_cnt;
  logic w_waiting;
  logic w_complete;
  logic w_to_hit;
  logic w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_start    = w_wr & (address == 2'd0) & writedata[0];
  assign w_abort    = w_wr & (address == 2'd0) & writedata[2];
  assign w_clr_done = w_wr & (address == 2'd1) & writedata[1];
  assign w_clr_to   = w_wr & (address == 2'd1) & writedata[2];
  assign w_wr_to    = w_wr & (address == 2'd2);
  assign w_wr_cnt   = w_wr & (address == 2'd3);
  assign w_unused   = ^writedata;

  // Exit condition beats an expiring timer on the same edge; ABORT beats both.
  always_comb begin
    w_waiting  = ((r_state == S_REQ) && !r_ack_s) || ((r_state == S_RELEASE) && r_ack_s);
    w_complete = (r_state == S_RELEASE) && !r_ack_s && !w_abort;
    w_to_hit   = w_waiting && r_to_on && (r_to_cnt == TO_W'(1)) && !w_abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= ack_in;
      r_ack_s    <= r_ack_meta;
    end
  end

  // The timer enable is captured at load so a later TIMEOUT write cannot affect it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_to_cnt <= '0;
      r_to_on  <= 1'b0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start && !r_ack_s) begin
            r_state  <= S_REQ;
            r_req    <= 1'b1;
            r_to_cnt <= r_timeout;
            r_to_on  <= |r_timeout;
          end
        end
        S_REQ: begin
          if (r_ack_s) begin
            r_state  <= S_RELEASE;
            r_req    <= 1'b0;
            r_to_cnt <= r_timeout;
            r_to_on  <= |r_timeout;
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else if (r_to_on) begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
          end
        end
        S_RELEASE: begin
          if (!r_ack_s) begin
            r_state <= S_IDLE;
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
          end else if (r_to_on) begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_to_err  <= 1'b0;
      r_timeout <= TO_W'(TIMEOUT_DEFAULT);
      r_count   <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && (address == 2'd0)) r_irq_en <= writedata[1];
      if (w_wr_to) r_timeout <= writedata[TO_W-1:0];
      r_done   <= w_complete | (r_done & ~w_clr_done);
      r_to_err <= w_to_hit | (r_to_err & ~w_clr_to);
      if (w_complete) r_count <= w_wr_cnt ? CNT_W'(1) : r_count + CNT_W'(1);
      else if (w_wr_cnt) r_count <= '0;
      r_irq <= r_irq_en & (r_done | r_to_err);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = '0;
      2'd1: readdata[3:0] = {r_ack_s, r_to_err, r_done, (r_state != S_IDLE)};
      2'd2: readdata[TO_W-1:0] = r_timeout;
      default: readdata[CNT_W-1:0] = r_count;
    endcase
  end

  assign req_out = r_req;
  assign irq     = r_irq;

endmodule
